// File: rtl/shift_tx_pkg.sv
// Shared types and constants for the 4-bit shift-register transmit sequencer.
// The PARITY state exists only when SHIFT_TX_PARITY_EN is defined.
package shift_tx_pkg;

    localparam int WORD_W = 4;

    localparam logic [1:0] SEL_HOLD   = 2'b00;
    localparam logic [1:0] SEL_TO_MSB = 2'b01;
    localparam logic [1:0] SEL_TO_LSB = 2'b10;
    localparam logic [1:0] SEL_LOAD   = 2'b11;

    // Down-counter preload for the SHIFT phase: it reaches zero on the last bit.
    localparam logic [3:0] LAST_BIT_CNT = 4'(WORD_W - 1);

`ifdef SHIFT_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_PARITY
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_e;
`endif

    function automatic logic even_parity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/shift_tx_bitcnt.sv
// Loadable down-counter shared by the bit phase and the inter-word gap.
// Load has priority over decrement; the counter saturates at zero.
module shift_tx_bitcnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/shift_tx_sequencer.sv
// Drives an external 4-bit universal shift register to serialise words, MSB- or LSB-first.
// Optional even-parity bit per word when SHIFT_TX_PARITY_EN is defined.
module shift_tx_sequencer
    import shift_tx_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic        FILL_BIT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              dir_i,
    output logic [1:0]        sel_o,
    output logic [WORD_W-1:0] pin_o,
    output logic              slin_o,
    output logic              srin_o,
    input  logic [WORD_W-1:0] pout_i,
    output logic              ser_o,
    output logic              ser_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              dir_q, dir_d;
    logic              run_q;
    logic              accept;
    logic              word_end;
    logic              cnt_load;
    logic [3:0]        cnt_load_val;
    logic              cnt_dec;
    logic              cnt_tc;

    shift_tx_bitcnt #(.CNT_W(4)) u_bitcnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

`ifdef SHIFT_TX_PARITY_EN
    assign word_end = (state_q == ST_PARITY);
`else
    assign word_end = (state_q == ST_SHIFT) && cnt_tc;
`endif

    // run_q keeps in_ready_o low for the first cycle after a reset edge.
    assign in_ready_o = run_q && ((state_q == ST_IDLE) || ((GAP_CYCLES == 0) && word_end));
    assign accept     = in_valid_i && in_ready_o;
    assign word_d     = accept ? in_data_i : word_q;
    assign dir_d      = accept ? dir_i : dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            dir_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = LAST_BIT_CNT;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d  = ST_SHIFT;
                cnt_load = 1'b1;
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
                if (cnt_tc) state_d = ST_PARITY;
`endif
            end
            ST_GAP: begin
                cnt_dec = 1'b1;
                if (cnt_tc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Common exit after the final serial bit of a word.
        if (word_end) begin
            if (GAP_CYCLES == 0) begin
                state_d = accept ? ST_LOAD : ST_IDLE;
            end else begin
                state_d      = ST_GAP;
                cnt_load     = 1'b1;
                cnt_load_val = GAP_LOAD;
            end
        end
    end

    always_comb begin
        sel_o       = SEL_HOLD;
        ser_valid_o = 1'b0;
        ser_o       = 1'b0;
        case (state_q)
            ST_LOAD: sel_o = SEL_LOAD;
            ST_SHIFT: begin
                sel_o       = dir_q ? SEL_TO_LSB : SEL_TO_MSB;
                ser_valid_o = 1'b1;
                ser_o       = dir_q ? pout_i[0] : pout_i[WORD_W-1];
            end
`ifdef SHIFT_TX_PARITY_EN
            ST_PARITY: begin
                ser_valid_o = 1'b1;
                ser_o       = even_parity(word_q);
            end
`endif
            default: sel_o = SEL_HOLD;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = word_end;
    assign pin_o  = word_q;
    assign slin_o = FILL_BIT;
    assign srin_o = FILL_BIT;

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Directed bench: two sequencers (GAP 0 and GAP 3), each closing the loop through a 4-bit shift register.
// Observed control bundle order: {in_ready, sel[1:0], ser_valid, ser, busy, done}.
module tb_shift_tx_sequencer;

`ifdef SHIFT_TX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk;
  logic rst;
  logic valid0, valid3;
  logic [3:0] data;
  logic dir;

  logic ready0, slin0, srin0, ser0, sv0, busy0, done0;
  logic [1:0] sel0;
  logic [3:0] pin0, sr0;
  logic ready3, slin3, srin3, ser3, sv3, busy3, done3;
  logic [1:0] sel3;
  logic [3:0] pin3, sr3;

  int n_vec;
  int n_err;

  logic [6:0] obs0, obs3;
  assign obs0 = {ready0, sel0, sv0, ser0, busy0, done0};
  assign obs3 = {ready3, sel3, sv3, ser3, busy3, done3};

  shift_tx_sequencer #(.GAP_CYCLES(0), .FILL_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid_i(valid0), .in_ready_o(ready0), .in_data_i(data),
    .dir_i(dir), .sel_o(sel0), .pin_o(pin0), .slin_o(slin0), .srin_o(srin0), .pout_i(sr0),
    .ser_o(ser0), .ser_valid_o(sv0), .busy_o(busy0), .done_o(done0)
  );

  shift_tx_sequencer #(.GAP_CYCLES(3), .FILL_BIT(1'b0)) dut3 (
    .clk(clk), .rst(rst), .in_valid_i(valid3), .in_ready_o(ready3), .in_data_i(data),
    .dir_i(dir), .sel_o(sel3), .pin_o(pin3), .slin_o(slin3), .srin_o(srin3), .pout_i(sr3),
    .ser_o(ser3), .ser_valid_o(sv3), .busy_o(busy3), .done_o(done3)
  );

  // Reference universal shift registers driven by the sequencers.
  always @(posedge clk) begin
    if (rst) sr0 <= 4'b0;
    else case (sel0)
      2'b01: sr0 <= {sr0[2:0], slin0};
      2'b10: sr0 <= {srin0, sr0[3:1]};
      2'b11: sr0 <= pin0;
      default: sr0 <= sr0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) sr3 <= 4'b0;
    else case (sel3)
      2'b01: sr3 <= {sr3[2:0], slin3};
      2'b10: sr3 <= {srin3, sr3[3:1]};
      2'b11: sr3 <= pin3;
      default: sr3 <= sr3;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks the NB serial-output cycles of one word; bits[k] is the k-th transmitted bit.
  task automatic shift_phase(input string tag, input bit use3, input logic d, input logic [4:0] bits);
    logic [1:0] esel;
    logic eready;
    logic last;
    for (int k = 0; k < NB; k++) begin
      step();
      last   = (k == NB - 1);
      esel   = (k < 4) ? (d ? 2'b10 : 2'b01) : 2'b00;
      eready = last && !use3;
      if (use3) chk($sformatf("%s_bit%0d", tag, k), obs3, {eready, esel, 1'b1, bits[k], 1'b1, last});
      else      chk($sformatf("%s_bit%0d", tag, k), obs0, {eready, esel, 1'b1, bits[k], 1'b1, last});
    end
  endtask

  // One word through dut0, with the inputs scrambled right after the handshake.
  task automatic word0(input string tag, input logic [3:0] w, input logic d, input logic [4:0] bits);
    data = w; dir = d; valid0 = 1'b1;
    step();
    valid0 = 1'b0; data = ~w; dir = ~d;
    chk({tag, "_load"}, obs0, 7'b0_11_0_0_1_0);
    chk({tag, "_pin"}, {3'b0, pin0}, {3'b0, w});
    shift_phase(tag, 1'b0, d, bits);
    step();
    chk({tag, "_idle"}, obs0, 7'b1_00_0_0_0_0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; valid0 = 1'b0; valid3 = 1'b0; data = 4'b0; dir = 1'b0;
    step();
    step();
    chk("rst_ctl0", obs0, 7'b0);
    chk("rst_ctl3", obs3, 7'b0);
    chk("rst_pin0", {3'b0, pin0}, 7'b0);
    rst = 1'b0;
    step();
    chk("post_rst_ready0", obs0, 7'b1_00_0_0_0_0);
    chk("post_rst_ready3", obs3, 7'b1_00_0_0_0_0);
    chk("fill_bits", {5'b0, slin0, srin0}, 7'b0);

    word0("w1011_msb", 4'b1011, 1'b0, 5'b11101);
    word0("w1011_lsb", 4'b1011, 1'b1, 5'b11011);
    word0("w0111_msb", 4'b0111, 1'b0, 5'b11110);

    // Back-to-back: A=0110 MSB-first, B=1001 LSB-first, valid held high.
    data = 4'b0110; dir = 1'b0; valid0 = 1'b1;
    step();
    chk("b2b_loadA", obs0, 7'b0_11_0_0_1_0);
    data = 4'b1001; dir = 1'b1;
    shift_phase("b2b_A", 1'b0, 1'b0, 5'b00110);
    step();
    valid0 = 1'b0;
    chk("b2b_loadB", obs0, 7'b0_11_0_0_1_0);
    chk("b2b_pinB", {3'b0, pin0}, 7'b000_1001);
    shift_phase("b2b_B", 1'b0, 1'b1, 5'b01001);
    step();
    chk("b2b_idle", obs0, 7'b1_00_0_0_0_0);

    // Reset during the second SHIFT cycle of 1100.
    data = 4'b1100; dir = 1'b0; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    step();
    chk("rmid_bit0", obs0, 7'b0_01_1_1_1_0);
    step();
    chk("rmid_bit1", obs0, 7'b0_01_1_1_1_0);
    rst = 1'b1;
    step();
    chk("rmid_zero", obs0, 7'b0);
    chk("rmid_pin", {3'b0, pin0}, 7'b0);
    rst = 1'b0;
    step();
    chk("rmid_ready", obs0, 7'b1_00_0_0_0_0);
    step();
    chk("rmid_no_done", obs0, 7'b1_00_0_0_0_0);

    // GAP_CYCLES=3 instance: word 0101 MSB-first.
    data = 4'b0101; dir = 1'b0; valid3 = 1'b1;
    step();
    valid3 = 1'b0;
    chk("gap_load", obs3, 7'b0_11_0_0_1_0);
    shift_phase("gap_w", 1'b1, 1'b0, 5'b01010);
    for (int g = 0; g < 3; g++) begin
      step();
      chk($sformatf("gap_hold%0d", g), obs3, 7'b0_00_0_0_1_0);
    end
    step();
    chk("gap_idle", obs3, 7'b1_00_0_0_0_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
